// File: rtl/l2_line_adapter.sv
// L2 line adapter: turns whole-line L2 read/write requests into 4-beat memory bursts.
// Optional watchdog enabled by defining L2_LINE_ADAPTER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a line request (write wins over read)
// RD_BURST | collecting read beats into the line buffer
// WR_BURST | presenting write beats from the latched line
// DONE     | one-cycle line_resp_o pulse, then back to IDLE
module l2_line_adapter #(
  parameter int LINE_W         = 256,
  parameter int BEAT_W         = 64,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [ADDR_W-1:0] line_addr_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              burst_read_o,
  output logic              burst_write_o,
  output logic [ADDR_W-1:0] burst_addr_o,
  output logic [BEAT_W-1:0] burst_wdata_o,
  input  logic [BEAT_W-1:0] burst_rdata_i,
  input  logic              burst_resp_i,
  output logic              error_o
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              in_burst;
  logic              last_beat;
  logic              tmo_hit;
  logic              unused_ok;

  assign in_burst  = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign last_beat = burst_resp_i && (cnt_q == CNT_W'(BEATS - 1));
  assign unused_ok = ^line_addr_i[OFF_W-1:0] ^ (TIMEOUT_CYCLES > 0);

`ifdef L2_LINE_ADAPTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic             error_q, error_d;

  assign tmo_hit = in_burst && !burst_resp_i && (wdog_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d  = wdog_q;
    error_d = error_q | tmo_hit;
    if (!in_burst || burst_resp_i || tmo_hit) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign tmo_hit = 1'b0;
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (line_write_i) begin
          state_d = WR_BURST;
        end else if (line_read_i) begin
          state_d = RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_beat || tmo_hit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read beats land in buf_q; line_rdata_o only changes when a full line has arrived,
  // so an aborted (timed-out) read never exposes a partial line.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (line_write_i || line_read_i) begin
          addr_d = {line_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        if (line_write_i) begin
          buf_d = line_wdata_i;
        end
      end
      RD_BURST, WR_BURST: begin
        if (burst_resp_i) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (state_q == RD_BURST) begin
            buf_d[cnt_q*BEAT_W +: BEAT_W] = burst_rdata_i;
            if (last_beat) begin
              rdata_d = buf_d;
            end
          end
        end
        if (tmo_hit) begin
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    line_resp_o   = (state_q == DONE);
    burst_read_o  = (state_q == RD_BURST);
    burst_write_o = (state_q == WR_BURST);
    burst_addr_o  = in_burst ? addr_q : '0;
    burst_wdata_o = (state_q == WR_BURST) ? buf_q[cnt_q*BEAT_W +: BEAT_W] : '0;
  end

  assign line_rdata_o = rdata_q;

endmodule

// File: doc/l2_line_adapter.md
Name: l2_line_adapter

Overview:
- Lower-memory responder that sits directly below the L2 data cache controller.
- Accepts the L2's whole-line read/write requests (pmem_read/pmem_write, held until response) and answers with a single-cycle resp.
- Converts each request into a 4-beat burst on the burst-memory bus: collects beats into a line for reads, serialises the line into beats for writes.

Parameters:
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, burst beat width in bits; BEATS = LINE_W/BEAT_W (4), counter width = clog2(BEATS)
- ADDR_W, 32, address width; line offset bits = clog2(LINE_W/8) (5)
- TIMEOUT_CYCLES, 1023, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- line_read_i  in  1  L2 line read request, level, held until line_resp_o
- line_write_i  in  1  L2 line write request, level, held until line_resp_o
- line_addr_i  in  ADDR_W  L2 line address
- line_wdata_i  in  LINE_W  write-back line
- line_rdata_o  out  LINE_W  fetched line
- line_resp_o  out  1  one-cycle completion pulse
- burst_read_o  out  1  memory burst read request
- burst_write_o  out  1  memory burst write request
- burst_addr_o  out  ADDR_W  line-aligned burst address
- burst_wdata_o  out  BEAT_W  current write beat
- burst_rdata_i  in  BEAT_W  read beat
- burst_resp_i  in  1  beat-valid strobe from memory; beats may be non-consecutive
- error_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n low): state IDLE, beat counter 0. Outputs line_rdata_o, line_resp_o, burst_read_o, burst_write_o, burst_addr_o, burst_wdata_o and error_o all 0.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - line_write_i high -> latch line_wdata_i and line_addr_i with low offset bits forced to 0; go to WR_BURST.
  - Else line_read_i high -> latch the address; go to RD_BURST.
  - Write has priority when both are high (a dirty write-back drains before the fetch).
  - burst_resp_i in IDLE is ignored.
- RD_BURST:
  - burst_read_o=1; burst_addr_o = latched address.
  - On each burst_resp_i: beat k (counter value) is written into line bits [k*BEAT_W +: BEAT_W]; counter increments.
  - On the beat with counter==BEATS-1: counter wraps to 0; go to DONE.
  - burst_read_o drops the cycle after the last beat.
- WR_BURST:
  - burst_write_o=1; burst_wdata_o = latched line beat[counter], beat 0 = bits [BEAT_W-1:0].
  - Each burst_resp_i advances the counter.
  - Last beat -> counter wraps to 0; go to DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle; next state IDLE unconditionally.
  - Minimum one IDLE cycle between transactions, so a request still held high during the DONE cycle is not re-accepted.
  - Latency: line_resp_o is asserted exactly one cycle after the cycle carrying the last burst_resp_i.
- line_rdata_o:
  - Updated only by read bursts; holds the last fetched line through writes and idle periods.
  - Valid when line_resp_o=1 for a read.
- Upstream deasserts its request mid-burst: ignored; the burst completes and line_resp_o still pulses.
- Address and write data are sampled only at acceptance; later changes on line_addr_i and line_wdata_i have no effect until the next acceptance.
- rst_n asserted mid-burst: immediate abort, all state and outputs cleared, memory request dropped.

Optional Feature:
- Macro L2_LINE_ADAPTER_TIMEOUT_EN.
- With macro:
  - A watchdog counter resets on entry to RD_BURST/WR_BURST and on every burst_resp_i, and increments in all other burst cycles.
  - Reaching TIMEOUT_CYCLES -> go to DONE: burst request dropped, line_resp_o pulsed (the L2 is not hung), line_rdata_o unchanged, error_o set.
  - error_o is sticky until reset.
- Without macro: no watchdog logic; error_o tied 0; a burst waits indefinitely for beats.

Test Plan:
- Read, line_addr_i=0x0000_1234, beats 0x11..11/0x22..22/0x33..33/0x44..44 on 4 consecutive cycles -> burst_addr_o=0x0000_1220; line_resp_o one cycle after beat 4; line_rdata_o={0x44..,0x33..,0x22..,0x11..}.
- Write, line_wdata_i={D3,D2,D1,D0}, burst_resp_i with 2-cycle gaps between beats -> burst_wdata_o steps D0,D1,D2,D3 only on resp; burst_write_o high until last beat; single line_resp_o.
- line_read_i and line_write_i high together in IDLE -> write burst first; read burst accepted after DONE+IDLE; two resp pulses.
- rst_n low after 2 read beats -> all outputs 0 asynchronously; a new read after reset returns the correct 4-beat line.
- Request held high through DONE -> no re-acceptance in DONE; exactly one IDLE cycle, then a new burst starts.
- With L2_LINE_ADAPTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no burst_resp_i -> line_resp_o after 8 cycles; error_o=1 and stays 1; line_rdata_o unchanged.
